instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage placed directly upstream of MemoriaDeInstrucciones. Owns the program counter.
//  Drives the PC onto the memory's ProgramCounter input and takes instructionOut back
//  combinationally in the same cycle. Registers that word into the IF/ID pipeline register
//  for the decoder. Handles stall, branch redirect/flush and, optionally, halt.
// PARAMETERS
//  ADDR_W       16      PC / instruction-address width (word addressed)
//  INSTR_W      16      instruction width
//  RESET_PC     16'h0   PC value loaded on reset
//  HALT_OPCODE  4'hF    instr[15:12] value treated as HALT (only with HALT_DETECT_EN)
// PORTS
//  clk           in   1        system clock; all state changes on rising edge
//  reset         in   1        synchronous, active-high reset
//  Stall         in   1        hold PC and IF/ID register (hazard from downstream)
//  BranchTaken   in   1        redirect fetch to BranchTarget and flush IF/ID
//  BranchTarget  in   ADDR_W   redirect address
//  MemInstr      in   INSTR_W  from MemoriaDeInstrucciones.instructionOut (combinational)
//  ProgramCounter out ADDR_W   current PC, to MemoriaDeInstrucciones.ProgramCounter
//  InstrOut      out  INSTR_W  IF/ID instruction register
//  PcOut         out  ADDR_W   IF/ID: address InstrOut was fetched from
//  PcPlusOne     out  ADDR_W   IF/ID: PcOut + 1 (link value)
//  InstrValid    out  1        IF/ID contents are a real instruction
//  Halted        out  1        fetch stopped on HALT (tied 0 without HALT_DETECT_EN)
// BEHAVIOUR
//  - Reset (sync, wins over everything): PC=RESET_PC; InstrOut=0; PcOut=0; PcPlusOne=0;
//    InstrValid=0; Halted=0. First valid IF/ID word appears 1 cycle after reset drops.
//  - Per-cycle priority: reset > BranchTaken > Stall > normal advance.
//  - Normal: IF/ID <= {MemInstr, PC, PC+1}; InstrValid<=1; PC <= PC+1. Latency 1 clk, 1 instr/clk.
//  - BranchTaken (even with Stall=1): PC <= BranchTarget; InstrValid<=0 (bubble); InstrOut
//    unchanged. Instruction at BranchTarget is registered the following cycle.
//  - Stall (no branch): PC, InstrOut, PcOut, PcPlusOne and InstrValid all hold.
//  - Arithmetic modulo 2^ADDR_W: PC 16'hFFFF advances to 16'h0000; PcPlusOne wraps identically.
//  - No FSM beyond the halt flag: states RUN (Halted=0) and HALT (Halted=1).
// CONFIGURATION
//  Macro HALT_DETECT_EN:
//   defined: a normal advance with MemInstr[15:12]==HALT_OPCODE registers the HALT word
//    (InstrValid=1) and sets Halted. In HALT: PC frozen; InstrValid<=0 from next cycle.
//    BranchTaken clears Halted and redirects, because the HALT was on a wrong path.
//    Only reset or branch leave HALT. Stall in HALT has no extra effect.
//   undefined: no opcode decode; Halted tied 0; HALT_OPCODE unused.
// STRUCTURE
//  Shared package cpu_pkg: ADDR_W/INSTR_W constants, HALT_OPCODE, RESET_PC, if_id_t struct
//  {instr, pc, pc_plus_one, valid}. Also used by decoder and hazard unit.
//  Single module, no sub-module; PC register and IF/ID register are inline always blocks.
// TESTING (bench instantiates this block with MemoriaDeInstrucciones; mem[i] preloaded)
//  1 Reset 2 clk then release -> ProgramCounter 0,1,2,3 on successive clks; PcOut lags by 1;
//    InstrValid=1 from first edge after reset; InstrOut==mem[PcOut].
//  2 Stall=1 for 3 clk at PC=5 -> PC stays 5, IF/ID holds addr 4 word; release -> PC 6, PcOut 5.
//  3 BranchTaken=1, BranchTarget=16'h0010 at PC=8 -> next clk PC=16, InstrValid=0;
//    following clk PcOut=16, InstrValid=1.
//  4 BranchTaken and Stall together -> branch wins: PC=BranchTarget, InstrValid=0.
//  5 Branch to 16'hFFFF -> PC FFFF then 0000; PcPlusOne for FFFF reads 0000.
//  6 HALT_DETECT_EN: mem[3]=16'hF000 -> PcOut=3 with InstrValid=1 and Halted=1; PC frozen at 4;
//    InstrValid=0 next clk; BranchTaken to 0 -> Halted=0, fetch restarts; reset mid-halt clears all.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath widths, reset PC, HALT opcode,
// the IF/ID bundle seen by decoder/hazard unit, and fetch states.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus_one;
    logic               valid;
  } if_id_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and the IF/ID register.
// HALT_DETECT_EN enables HALT opcode detection and the halt flag.
module instruction_fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
`ifdef HALT_DETECT_EN
  ,
  parameter logic [3:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic [INSTR_W-1:0] MemInstr,
  output logic [ADDR_W-1:0]  ProgramCounter,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  PcOut,
  output logic [ADDR_W-1:0]  PcPlusOne,
  output logic               InstrValid,
  output logic               Halted
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcout_q, pcout_d;
  logic [ADDR_W-1:0]  pp1_q, pp1_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef HALT_DETECT_EN
  cpu_pkg::fetch_state_e state_q, state_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcout_q <= '0;
      pp1_q   <= '0;
      valid_q <= 1'b0;
`ifdef HALT_DETECT_EN
      state_q <= cpu_pkg::RUN;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      pp1_q   <= pp1_d;
      valid_q <= valid_d;
`ifdef HALT_DETECT_EN
      state_q <= state_d;
`endif
    end
  end

  // Branch beats stall: the stalled slot is on the wrong path anyway.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcout_d = pcout_q;
    pp1_d   = pp1_q;
    valid_d = valid_q;
`ifdef HALT_DETECT_EN
    state_d = state_q;
`endif
    if (BranchTaken) begin
      pc_d    = BranchTarget;
      valid_d = 1'b0;
`ifdef HALT_DETECT_EN
      state_d = cpu_pkg::RUN;
`endif
    end
`ifdef HALT_DETECT_EN
    else if (state_q == cpu_pkg::HALT) begin
      valid_d = 1'b0;
    end
`endif
    else if (!Stall) begin
      pc_d    = pc_inc;
      instr_d = MemInstr;
      pcout_d = pc_q;
      pp1_d   = pc_inc;
      valid_d = 1'b1;
`ifdef HALT_DETECT_EN
      if (MemInstr[INSTR_W-1 -: 4] == HALT_OPCODE)
        state_d = cpu_pkg::HALT;
`endif
    end
  end

  assign ProgramCounter = pc_q;
  assign InstrOut       = instr_q;
  assign PcOut          = pcout_q;
  assign PcPlusOne      = pp1_q;
  assign InstrValid     = valid_q;
`ifdef HALT_DETECT_EN
  assign Halted = (state_q == cpu_pkg::HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural
// instruction memory; HALT steps compile only with HALT_DETECT_EN.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic [15:0] MemInstr;
  logic [15:0] ProgramCounter;
  logic [15:0] InstrOut;
  logic [15:0] PcOut;
  logic [15:0] PcPlusOne;
  logic        InstrValid;
  logic        Halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  assign MemInstr = mem[ProgramCounter];

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .MemInstr(MemInstr),
    .ProgramCounter(ProgramCounter),
    .InstrOut(InstrOut),
    .PcOut(PcOut),
    .PcPlusOne(PcPlusOne),
    .InstrValid(InstrValid),
    .Halted(Halted)
  );

  function automatic logic [15:0] img(input logic [15:0] a);
    return {4'h1, a[11:0] ^ 12'h5A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [15:0] pc,
                        input logic [15:0] pco, input logic v);
    chk({tag, " pc"}, 32'(ProgramCounter), 32'(pc));
    chk({tag, " pcout"}, 32'(PcOut), 32'(pco));
    chk({tag, " valid"}, 32'(InstrValid), 32'(v));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = img(16'(i));
    reset = 1'b1;
    Stall = 1'b0;
    BranchTaken = 1'b0;
    BranchTarget = '0;

    tick();
    tick();
    chk("rst pc", 32'(ProgramCounter), 32'h0);
    chk("rst instr", 32'(InstrOut), 32'h0);
    chk("rst pcout", 32'(PcOut), 32'h0);
    chk("rst pp1", 32'(PcPlusOne), 32'h0);
    chk("rst valid", 32'(InstrValid), 32'h0);
    chk("rst halted", 32'(Halted), 32'h0);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_if("seq", 16'(k), 16'(k - 1), 1'b1);
      chk("seq instr", 32'(InstrOut), 32'(img(16'(k - 1))));
      chk("seq pp1", 32'(PcPlusOne), 32'(k));
    end

    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_if("stall", 16'd5, 16'd4, 1'b1);
      chk("stall instr", 32'(InstrOut), 32'(img(16'd4)));
    end
    Stall = 1'b0;
    tick();
    chk_if("unstall", 16'd6, 16'd5, 1'b1);
    chk("unstall instr", 32'(InstrOut), 32'(img(16'd5)));
    tick();
    tick();
    chk_if("pre br", 16'd8, 16'd7, 1'b1);

    BranchTaken = 1'b1;
    BranchTarget = 16'h0010;
    tick();
    BranchTaken = 1'b0;
    chk_if("br", 16'h0010, 16'd7, 1'b0);
    chk("br instr held", 32'(InstrOut), 32'(img(16'd7)));
    tick();
    chk_if("br tgt", 16'h0011, 16'h0010, 1'b1);
    chk("br tgt instr", 32'(InstrOut), 32'(img(16'h0010)));

    BranchTaken = 1'b1;
    Stall = 1'b1;
    BranchTarget = 16'h0030;
    tick();
    BranchTaken = 1'b0;
    Stall = 1'b0;
    chk_if("br+stall", 16'h0030, 16'h0010, 1'b0);
    tick();
    chk_if("br+stall tgt", 16'h0031, 16'h0030, 1'b1);

    BranchTaken = 1'b1;
    BranchTarget = 16'hFFFF;
    tick();
    BranchTaken = 1'b0;
    chk_if("wrap br", 16'hFFFF, 16'h0030, 1'b0);
    tick();
    chk_if("wrap", 16'h0000, 16'hFFFF, 1'b1);
    chk("wrap pp1", 32'(PcPlusOne), 32'h0000);
    chk("wrap instr", 32'(InstrOut), 32'(img(16'hFFFF)));
    tick();
    chk_if("wrap next", 16'h0001, 16'h0000, 1'b1);
    chk("wrap next pp1", 32'(PcPlusOne), 32'h0001);
    chk("no halt", 32'(Halted), 32'h0);

    reset = 1'b1;
    tick();
    chk_if("rst2", 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;

`ifdef HALT_DETECT_EN
    mem[3] = 16'hF000;
    for (int k = 0; k < 4; k++) tick();
    chk_if("halt hit", 16'd4, 16'd3, 1'b1);
    chk("halt instr", 32'(InstrOut), 32'hF000);
    chk("halt flag", 32'(Halted), 32'h1);
    tick();
    chk_if("halt hold", 16'd4, 16'd3, 1'b0);
    chk("halt hold flag", 32'(Halted), 32'h1);
    Stall = 1'b1;
    tick();
    Stall = 1'b0;
    chk_if("halt stall", 16'd4, 16'd3, 1'b0);
    BranchTaken = 1'b1;
    BranchTarget = 16'h0000;
    tick();
    BranchTaken = 1'b0;
    chk_if("halt br", 16'd0, 16'd3, 1'b0);
    chk("halt br flag", 32'(Halted), 32'h0);
    tick();
    chk_if("halt restart", 16'd1, 16'd0, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    chk("halt again", 32'(Halted), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_if("halt rst", 16'd0, 16'd0, 1'b0);
    chk("halt rst flag", 32'(Halted), 32'h0);
    mem[3] = img(16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
